// File: rtl/hub_link_pkg.sv
`default_nettype none
// ============================================================================
// Package     : hub_link_pkg
// Description : Shared definitions for the leaf end of the root hub link:
//               header field positions, well-known channel IDs and the
//               RX/TX message framing state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package hub_link_pkg;

    // Header word layout: [63:56] dest, [55:52] len, [51:48] type,
    // [47:40] src, [39:0] header payload.
    localparam int unsigned c_DEST_MSB = 63;
    localparam int unsigned c_DEST_LSB = 56;
    localparam int unsigned c_LEN_MSB  = 55;
    localparam int unsigned c_LEN_LSB  = 52;
    localparam int unsigned c_TYPE_MSB = 51;
    localparam int unsigned c_TYPE_LSB = 48;
    localparam int unsigned c_SRC_MSB  = 47;
    localparam int unsigned c_SRC_LSB  = 40;
    localparam int unsigned c_LEN_W    = 4;
    localparam int unsigned c_ID_W     = 8;

    localparam logic [c_ID_W-1:0] c_ROOT_ID      = 8'h00;
    localparam logic [c_ID_W-1:0] c_BROADCAST_ID = 8'hFF;

    typedef enum logic [1:0] {
        RX_HDR  = 2'd0,
        RX_FWD  = 2'd1,
        RX_DROP = 2'd2
    } rx_state_e;

    typedef enum logic [0:0] {
        TX_HDR = 1'b0,
        TX_PAY = 1'b1
    } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/leaf_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module      : leaf_skid_buffer
// Description : Two-entry registered valid/ready buffer. Output and input
//               ready are both driven from flops, so no combinational path
//               crosses it. One cycle latency, full throughput.
// Ports       : clk, rst_n (async, active-low)
//               i_data/i_valid/o_ready  - upstream side
//               o_data/o_valid/i_ready  - downstream side
// Revision    : 1.0 - initial release
// ============================================================================
module leaf_skid_buffer #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready
);

    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_skid_data;
    logic             r_skid_valid;
    logic             r_in_ready;

    logic w_push;
    logic w_pop;
    logic w_out_load;
    logic w_skid_valid_nxt;

    assign w_push     = i_valid & r_in_ready;
    assign w_pop      = r_out_valid & i_ready;
    assign w_out_load = w_pop | ~r_out_valid;

    // The skid entry only fills while the output entry is stalled; whenever
    // the output entry is free it drains the skid entry (or takes the input).
    assign w_skid_valid_nxt = w_out_load ? 1'b0 : (r_skid_valid | w_push);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_skid_data  <= '0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b0;
        end else begin
            if (w_out_load) begin
                if (r_skid_valid) begin
                    r_out_data  <= r_skid_data;
                    r_out_valid <= 1'b1;
                end else begin
                    r_out_valid <= w_push;
                    if (w_push) begin
                        r_out_data <= i_data;
                    end
                end
            end else if (w_push) begin
                r_skid_data <= i_data;
            end
            r_skid_valid <= w_skid_valid_nxt;
            // Ready is "not full": at most one entry occupied next cycle.
            r_in_ready   <= ~w_skid_valid_nxt;
        end
    end

    assign o_ready = r_in_ready;
    assign o_data  = r_out_data;
    assign o_valid = r_out_valid;

endmodule
`default_nettype wire

// File: rtl/leaf_hub_link.sv
`default_nettype none
// ============================================================================
// Module      : leaf_hub_link
// Description : Child-FPGA end of the root hub link. Downstream messages are
//               filtered by destination ID and delivered to the local leaf
//               controller; upstream messages get dest=ROOT_ID and
//               src=FPGA_ID stamped into the header. Both directions pass
//               through a leaf_skid_buffer.
// Ports       : clk, reset (async, active-low)
//               rx_*              - words from root hub
//               data/valid/ready_to_local   - delivered words
//               data/valid/ready_from_local - local outbound words
//               tx_*              - words to root hub
//               drop_count/fwd_count - header statistics (LEAF_HUB_STATS_EN)
// Options     : define LEAF_HUB_STATS_EN to add the saturating counters.
// Revision    : 1.0 - initial release
// ============================================================================
module leaf_hub_link
    import hub_link_pkg::*;
#(
    parameter int unsigned            CHANNEL_WIDTH = 64,
    parameter int unsigned            DEST_WIDTH    = 8,
    parameter logic [DEST_WIDTH-1:0]  FPGA_ID       = 1,
    parameter logic [DEST_WIDTH-1:0]  BROADCAST_ID  = c_BROADCAST_ID,
    parameter logic [DEST_WIDTH-1:0]  ROOT_ID       = c_ROOT_ID
) (
`ifdef LEAF_HUB_STATS_EN
    output logic [15:0]               drop_count,
    output logic [15:0]               fwd_count,
`endif
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNEL_WIDTH-1:0]  rx_data,
    input  logic                      rx_valid,
    output logic                      rx_ready,
    output logic [CHANNEL_WIDTH-1:0]  tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    output logic [CHANNEL_WIDTH-1:0]  data_to_local,
    output logic                      valid_to_local,
    input  logic                      ready_to_local,
    input  logic [CHANNEL_WIDTH-1:0]  data_from_local,
    input  logic                      valid_from_local,
    output logic                      ready_from_local
);

    // ---------------------------------------------------------------- RX ---
    rx_state_e          r_rx_state;
    logic [c_LEN_W-1:0] r_rx_cnt;

    logic [DEST_WIDTH-1:0] w_rx_dest;
    logic [c_LEN_W-1:0]    w_rx_len;
    logic                  w_rx_match;
    logic                  w_rx_xfer;
    logic                  w_rx_hdr_xfer;
    logic                  w_dn_ready;
    logic                  w_dn_push;

    assign w_rx_dest     = rx_data[c_DEST_MSB:c_DEST_LSB];
    assign w_rx_len      = rx_data[c_LEN_MSB:c_LEN_LSB];
    assign w_rx_match    = (w_rx_dest == FPGA_ID) || (w_rx_dest == BROADCAST_ID);
    // Dropped payload is sunk regardless of downstream space; headers are
    // only taken when the buffer has room, whether they match or not.
    assign rx_ready      = (r_rx_state == RX_DROP) ? 1'b1 : w_dn_ready;
    assign w_rx_xfer     = rx_valid & rx_ready;
    assign w_rx_hdr_xfer = w_rx_xfer & (r_rx_state == RX_HDR);
    assign w_dn_push     = (w_rx_hdr_xfer & w_rx_match) |
                           (w_rx_xfer & (r_rx_state == RX_FWD));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_state <= RX_HDR;
            r_rx_cnt   <= '0;
        end else if (w_rx_xfer) begin
            case (r_rx_state)
                RX_HDR: begin
                    if (w_rx_len != '0) begin
                        r_rx_state <= w_rx_match ? RX_FWD : RX_DROP;
                        r_rx_cnt   <= w_rx_len;
                    end
                end
                RX_FWD, RX_DROP: begin
                    if (r_rx_cnt == c_LEN_W'(1)) begin
                        r_rx_state <= RX_HDR;
                    end
                    r_rx_cnt <= r_rx_cnt - c_LEN_W'(1);
                end
                default: r_rx_state <= RX_HDR;
            endcase
        end
    end

    leaf_skid_buffer #(
        .WIDTH (CHANNEL_WIDTH)
    ) u_dn_skid (
        .clk     (clk),
        .rst_n   (reset),
        .i_data  (rx_data),
        .i_valid (w_dn_push),
        .o_ready (w_dn_ready),
        .o_data  (data_to_local),
        .o_valid (valid_to_local),
        .i_ready (ready_to_local)
    );

    // ---------------------------------------------------------------- TX ---
    tx_state_e          r_tx_state;
    logic [c_LEN_W-1:0] r_tx_cnt;

    logic [CHANNEL_WIDTH-1:0] w_up_data;
    logic [c_LEN_W-1:0]       w_tx_len;
    logic                     w_tx_xfer;

    assign w_tx_len  = data_from_local[c_LEN_MSB:c_LEN_LSB];
    assign w_tx_xfer = valid_from_local & ready_from_local;

    always_comb begin
        w_up_data = data_from_local;
        if (r_tx_state == TX_HDR) begin
            w_up_data[c_DEST_MSB:c_DEST_LSB] = ROOT_ID;
            w_up_data[c_SRC_MSB:c_SRC_LSB]   = FPGA_ID;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_state <= TX_HDR;
            r_tx_cnt   <= '0;
        end else if (w_tx_xfer) begin
            case (r_tx_state)
                TX_HDR: begin
                    if (w_tx_len != '0) begin
                        r_tx_state <= TX_PAY;
                        r_tx_cnt   <= w_tx_len;
                    end
                end
                TX_PAY: begin
                    if (r_tx_cnt == c_LEN_W'(1)) begin
                        r_tx_state <= TX_HDR;
                    end
                    r_tx_cnt <= r_tx_cnt - c_LEN_W'(1);
                end
                default: r_tx_state <= TX_HDR;
            endcase
        end
    end

    leaf_skid_buffer #(
        .WIDTH (CHANNEL_WIDTH)
    ) u_up_skid (
        .clk     (clk),
        .rst_n   (reset),
        .i_data  (w_up_data),
        .i_valid (valid_from_local),
        .o_ready (ready_from_local),
        .o_data  (tx_data),
        .o_valid (tx_valid),
        .i_ready (tx_ready)
    );

`ifdef LEAF_HUB_STATS_EN
    // ------------------------------------------------------------- stats ---
    logic [15:0] r_drop_count;
    logic [15:0] r_fwd_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_drop_count <= '0;
            r_fwd_count  <= '0;
        end else if (w_rx_hdr_xfer) begin
            if (w_rx_match && (r_fwd_count != 16'hFFFF)) begin
                r_fwd_count <= r_fwd_count + 16'd1;
            end
            if (!w_rx_match && (r_drop_count != 16'hFFFF)) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    assign drop_count = r_drop_count;
    assign fwd_count  = r_fwd_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_leaf_hub_link.sv
`default_nettype none
// ============================================================================
// Module      : tb_leaf_hub_link
// Description : Directed self-checking bench for leaf_hub_link.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_leaf_hub_link;

    logic        clk;
    logic        reset;
    logic [63:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [63:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [63:0] data_to_local;
    logic        valid_to_local;
    logic        ready_to_local;
    logic [63:0] data_from_local;
    logic        valid_from_local;
    logic        ready_from_local;
`ifdef LEAF_HUB_STATS_EN
    logic [15:0] drop_count;
    logic [15:0] fwd_count;
`endif

    int n_assert;
    int n_fail;

    logic [63:0] rx_exp [8];
    logic [63:0] tx_exp [8];

    leaf_hub_link #(
        .FPGA_ID (8'd1)
    ) dut (
`ifdef LEAF_HUB_STATS_EN
        .drop_count       (drop_count),
        .fwd_count        (fwd_count),
`endif
        .clk              (clk),
        .reset            (reset),
        .rx_data          (rx_data),
        .rx_valid         (rx_valid),
        .rx_ready         (rx_ready),
        .tx_data          (tx_data),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready),
        .data_to_local    (data_to_local),
        .valid_to_local   (valid_to_local),
        .ready_to_local   (ready_to_local),
        .data_from_local  (data_from_local),
        .valid_from_local (valid_from_local),
        .ready_from_local (ready_from_local)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word on rx and hold it until it transfers.
    task automatic send_rx(input logic [63:0] w);
        int n;
        n = 0;
        rx_data  = w;
        rx_valid = 1'b1;
        while (!rx_ready && n < 100) begin
            tick();
            n++;
        end
        if (!rx_ready) chk("rx_send_timeout", 64'(rx_ready), 64'd1);
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_tx(input logic [63:0] w);
        int n;
        n = 0;
        data_from_local  = w;
        valid_from_local = 1'b1;
        while (!ready_from_local && n < 100) begin
            tick();
            n++;
        end
        if (!ready_from_local) chk("tx_send_timeout", 64'(ready_from_local), 64'd1);
        tick();
        valid_from_local = 1'b0;
    endtask

    // Sink n words from the local side, comparing in order against rx_exp.
    task automatic collect_rx(input int n, input bit rnd);
        int idx;
        int cyc;
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 300) begin
            @(negedge clk);
            ready_to_local = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (valid_to_local && ready_to_local) begin
                chk($sformatf("rx_word%0d", idx), data_to_local, rx_exp[idx]);
                idx++;
            end
            cyc++;
        end
        chk("rx_collect_count", 64'(idx), 64'(n));
        tick();
        ready_to_local = 1'b1;
    endtask

    task automatic collect_tx(input int n, input bit rnd);
        int idx;
        int cyc;
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 300) begin
            @(negedge clk);
            tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (tx_valid && tx_ready) begin
                chk($sformatf("tx_word%0d", idx), tx_data, tx_exp[idx]);
                idx++;
            end
            cyc++;
        end
        chk("tx_collect_count", 64'(idx), 64'(n));
        tick();
        tx_ready = 1'b1;
    endtask

    initial begin
        n_assert         = 0;
        n_fail           = 0;
        reset            = 1'b0;
        rx_data          = '0;
        rx_valid         = 1'b0;
        tx_ready         = 1'b1;
        ready_to_local   = 1'b1;
        data_from_local  = '0;
        valid_from_local = 1'b0;

        // ---------------- reset state
        tick();
        tick();
        chk("rst_rx_ready",   64'(rx_ready), 64'd0);
        chk("rst_rdy_from",   64'(ready_from_local), 64'd0);
        chk("rst_valid_loc",  64'(valid_to_local), 64'd0);
        chk("rst_tx_valid",   64'(tx_valid), 64'd0);
        chk("rst_data_loc",   data_to_local, 64'd0);
        chk("rst_tx_data",    tx_data, 64'd0);
        reset = 1'b1;
        tick();
        chk("post_rst_rx_ready", 64'(rx_ready), 64'd1);
        chk("post_rst_rdy_from", 64'(ready_from_local), 64'd1);

        // ---------------- forward dest=1 len=2
        send_rx(64'h0120_0000_0000_1111);
        chk("fwd_hdr_valid", 64'(valid_to_local), 64'd1);
        chk("fwd_hdr_data",  data_to_local, 64'h0120_0000_0000_1111);
        send_rx(64'hDEAD_BEEF_0000_0001);
        chk("fwd_p1_data",   data_to_local, 64'hDEAD_BEEF_0000_0001);
        send_rx(64'hDEAD_BEEF_0000_0002);
        chk("fwd_p2_data",   data_to_local, 64'hDEAD_BEEF_0000_0002);
        chk("fwd_p2_valid",  64'(valid_to_local), 64'd1);
        tick();
        chk("fwd_idle_valid", 64'(valid_to_local), 64'd0);
`ifdef LEAF_HUB_STATS_EN
        chk("fwd_count1", 64'(fwd_count), 64'd1);
`endif

        // ---------------- drop dest=3 len=3, then broadcast len=0
        send_rx(64'h0330_0000_0000_2222);
        chk("drop_hdr_valid", 64'(valid_to_local), 64'd0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("drop_p%0d_ready", i), 64'(rx_ready), 64'd1);
            send_rx(64'hBAD0_0000_0000_0000 | 64'(i));
            chk($sformatf("drop_p%0d_valid", i), 64'(valid_to_local), 64'd0);
        end
        send_rx(64'hFF00_0000_0000_0042);
        chk("bcast_valid", 64'(valid_to_local), 64'd1);
        chk("bcast_data",  data_to_local, 64'hFF00_0000_0000_0042);
        tick();
`ifdef LEAF_HUB_STATS_EN
        chk("drop_count1", 64'(drop_count), 64'd1);
        chk("fwd_count2",  64'(fwd_count), 64'd2);
`endif

        // ---------------- tx header stamping
        send_tx(64'h0000_0000_0000_ABCD);
        chk("tx0_valid", 64'(tx_valid), 64'd1);
        chk("tx0_data",  tx_data, 64'h0000_0100_0000_ABCD);
        send_tx(64'h7720_AA55_0000_0000);
        chk("tx1_hdr",   tx_data, 64'h0020_0155_0000_0000);
        send_tx(64'hFFFF_FFFF_0000_0001);
        chk("tx1_p1",    tx_data, 64'hFFFF_FFFF_0000_0001);
        send_tx(64'hFFFF_FFFF_0000_0002);
        chk("tx1_p2",    tx_data, 64'hFFFF_FFFF_0000_0002);
        send_tx(64'h5500_3300_0000_0007);
        chk("tx2_hdr",   tx_data, 64'h0000_0100_0000_0007);
        tick();
        chk("tx_idle_valid", 64'(tx_valid), 64'd0);

        // ---------------- back-pressure during len=4 forward
        rx_exp[0] = 64'h0140_0000_0000_3000;
        for (int i = 1; i < 5; i++) rx_exp[i] = 64'h3333_0000_0000_0000 | 64'(i);
        ready_to_local = 1'b0;
        send_rx(rx_exp[0]);
        send_rx(rx_exp[1]);
        chk("bp_rx_ready_low", 64'(rx_ready), 64'd0);
        tick();
        tick();
        chk("bp_hold_valid", 64'(valid_to_local), 64'd1);
        chk("bp_hold_data",  data_to_local, rx_exp[0]);
        chk("bp_rx_ready_still_low", 64'(rx_ready), 64'd0);
        fork
            begin
                for (int i = 2; i < 5; i++) send_rx(rx_exp[i]);
            end
            collect_rx(5, 1'b0);
        join
        tick();
        chk("bp_no_dup", 64'(valid_to_local), 64'd0);

        // ---------------- concurrent rx/tx with random sink ready
        rx_exp[0] = 64'h0130_0000_0000_0010;
        for (int i = 1; i < 4; i++) rx_exp[i] = 64'h4444_0000_0000_0010 | 64'(i);
        tx_exp[0] = 64'h0035_0100_1234_5678;
        for (int i = 1; i < 4; i++) tx_exp[i] = 64'h5555_0000_0000_0020 | 64'(i);
        fork
            begin
                for (int i = 0; i < 4; i++) send_rx(rx_exp[i]);
            end
            collect_rx(4, 1'b1);
            begin
                send_tx(64'hAB35_CC00_1234_5678);
                for (int i = 1; i < 4; i++) send_tx(tx_exp[i]);
            end
            collect_tx(4, 1'b1);
        join
        tick();

        // ---------------- reset mid-message (RX_FWD, rx_cnt=2)
        send_rx(64'h0130_0000_0000_0020);
        send_rx(64'h6666_0000_0000_0001);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid_loc", 64'(valid_to_local), 64'd0);
        chk("mid_rst_tx_valid",  64'(tx_valid), 64'd0);
        chk("mid_rst_rx_ready",  64'(rx_ready), 64'd0);
        chk("mid_rst_data_loc",  data_to_local, 64'd0);
`ifdef LEAF_HUB_STATS_EN
        chk("mid_rst_fwd_count", 64'(fwd_count), 64'd0);
`endif
        tick();
        reset = 1'b1;
        // Non-matching single-word header: dropped only if seen as a header.
        send_rx(64'h0900_0000_0000_0001);
        chk("post_rst_hdr_dropped", 64'(valid_to_local), 64'd0);
        send_rx(64'h0100_0000_0000_00AA);
        chk("post_rst_hdr_valid", 64'(valid_to_local), 64'd1);
        chk("post_rst_hdr_data",  data_to_local, 64'h0100_0000_0000_00AA);
        tick();
`ifdef LEAF_HUB_STATS_EN
        chk("post_rst_drop_count", 64'(drop_count), 64'd1);
        chk("post_rst_fwd_count",  64'(fwd_count), 64'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
